// File: rtl/fpu_addsub_pipe.sv
// Multi-cycle floating-point adder/subtractor, fixed 6-cycle start-to-done latency.
// Define FPU_ROUND_EN for round-to-nearest (ties away from zero); otherwise the result is truncated.
module fpu_addsub_pipe #(
  parameter int EXP_W = 7,
  parameter int MAN_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             a_s,
  input  logic             b_s,
  input  logic [EXP_W-1:0] a_e,
  input  logic [EXP_W-1:0] b_e,
  input  logic [MAN_W-1:0] a_m,
  input  logic [MAN_W-1:0] b_m,
  output logic             res_s,
  output logic [EXP_W-1:0] res_e,
  output logic [MAN_W-1:0] res_m,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic             underflow_flag,
  output logic             invalid_flag,
  output logic             busy,
  output logic             done
);

  localparam int XW = EXP_W + 1;
  localparam int SW = MAN_W + 2;
  localparam logic signed [XW-1:0] EMAX_X  = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMIN_X  = XW'(-(2 ** (EXP_W - 1)));
  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] EHI_X   = EMAX_X - ONE_X;
  localparam logic signed [XW-1:0] ELO_X   = EMIN_X + ONE_X;
  localparam logic [EXP_W-1:0]     EMAX    = EMAX_X[EXP_W-1:0];
  localparam logic [EXP_W-1:0]     EMIN    = EMIN_X[EXP_W-1:0];
  localparam logic [MAN_W-1:0]     CANON_M = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [XW-1:0]        MAN_W_X = XW'(MAN_W);

  // Priority encoder: number of leading zeros above the first set bit.
  function automatic logic [XW-1:0] lead_zeros(input logic [MAN_W:0] v);
    lead_zeros = XW'(MAN_W + 1);
    for (int i = 0; i <= MAN_W; i++)
      if (v[i]) lead_zeros = XW'(MAN_W - i);
  endfunction

  // Returns {carry_out, mantissa}; input is the normalised mantissa with guard bit at the LSB.
  function automatic logic [MAN_W:0] round_man(input logic [MAN_W:0] nm);
`ifdef FPU_ROUND_EN
    round_man = {1'b0, nm[MAN_W:1]} + {{MAN_W{1'b0}}, nm[0]};
`else
    round_man = {1'b0, nm[MAN_W:1]};
`endif
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_UNPACK;
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ADDSUB;
      S_ADDSUB: w_next = S_NORM;
      S_NORM:   w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   w_next = start ? S_UNPACK : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_UNPACK) || (r_state == S_ALIGN) || (r_state == S_ADDSUB) ||
           (r_state == S_NORM) || (r_state == S_ROUND);
    done = (r_state == S_DONE);
  end

  assign w_accept = start & ~busy;

  // ---- capture: operands latched on an accepted start, B sign made effective
  logic             r_a_s_p0, r_b_s_p0;
  logic [EXP_W-1:0] r_a_e_p0, r_b_e_p0;
  logic [MAN_W-1:0] r_a_m_p0, r_b_m_p0;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_s_p0 <= a_s;
      r_a_e_p0 <= a_e;
      r_a_m_p0 <= a_m;
      r_b_s_p0 <= b_s ^ sub;
      r_b_e_p0 <= b_e;
      r_b_m_p0 <= b_m;
    end
  end

  // ---- UNPACK: order by magnitude, exponent difference, special operands
  logic             w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_eff_sub, w_a_ge;
  logic             w_l_s;
  logic [EXP_W-1:0] w_l_e, w_s_e;
  logic [MAN_W-1:0] w_l_m, w_s_m;
  logic [XW-1:0]    w_d;
  logic             w_spec, w_spec_s, w_spec_zero, w_spec_inv;
  logic [EXP_W-1:0] w_spec_e;
  logic [MAN_W-1:0] w_spec_m;

  assign w_a_inf   = (r_a_e_p0 == EMAX);
  assign w_b_inf   = (r_b_e_p0 == EMAX);
  assign w_a_zero  = (r_a_e_p0 == EMIN);
  assign w_b_zero  = (r_b_e_p0 == EMIN);
  assign w_eff_sub = r_a_s_p0 ^ r_b_s_p0;
  assign w_a_ge    = ($signed(r_a_e_p0) > $signed(r_b_e_p0)) ||
                     ((r_a_e_p0 == r_b_e_p0) && (r_a_m_p0 >= r_b_m_p0));
  assign w_l_s     = w_a_ge ? r_a_s_p0 : r_b_s_p0;
  assign w_l_e     = w_a_ge ? r_a_e_p0 : r_b_e_p0;
  assign w_l_m     = w_a_ge ? r_a_m_p0 : r_b_m_p0;
  assign w_s_e     = w_a_ge ? r_b_e_p0 : r_a_e_p0;
  assign w_s_m     = w_a_ge ? r_b_m_p0 : r_a_m_p0;
  assign w_d       = {w_l_e[EXP_W-1], w_l_e} - {w_s_e[EXP_W-1], w_s_e};

  always_comb begin
    w_spec      = 1'b1;
    w_spec_s    = 1'b0;
    w_spec_e    = EMAX;
    w_spec_m    = CANON_M;
    w_spec_zero = 1'b0;
    w_spec_inv  = 1'b0;
    if (w_a_inf && w_b_inf && w_eff_sub) begin
      w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_s = r_a_s_p0;
    end else if (w_b_inf) begin
      w_spec_s = r_b_s_p0;
    end else if (w_a_zero && w_b_zero) begin
      w_spec_e    = EMIN;
      w_spec_zero = 1'b1;
    end else if (w_a_zero) begin
      w_spec_s = r_b_s_p0;
      w_spec_e = r_b_e_p0;
      w_spec_m = r_b_m_p0;
    end else if (w_b_zero) begin
      w_spec_s = r_a_s_p0;
      w_spec_e = r_a_e_p0;
      w_spec_m = r_a_m_p0;
    end else begin
      w_spec = 1'b0;
    end
  end

  logic                    r_l_s_p1, r_eff_sub_p1;
  logic signed [XW-1:0]    r_l_e_p1;
  logic [MAN_W-1:0]        r_l_m_p1, r_s_m_p1;
  logic [XW-1:0]           r_d_p1;
  logic                    r_spec_p1, r_spec_s_p1, r_spec_zero_p1, r_spec_inv_p1;
  logic [EXP_W-1:0]        r_spec_e_p1;
  logic [MAN_W-1:0]        r_spec_m_p1;

  always_ff @(posedge clk) begin
    if (r_state == S_UNPACK) begin
      r_l_s_p1       <= w_l_s;
      r_l_e_p1       <= {w_l_e[EXP_W-1], w_l_e};
      r_l_m_p1       <= w_l_m;
      r_s_m_p1       <= w_s_m;
      r_d_p1         <= w_d;
      r_eff_sub_p1   <= w_eff_sub;
      r_spec_p1      <= w_spec;
      r_spec_s_p1    <= w_spec_s;
      r_spec_e_p1    <= w_spec_e;
      r_spec_m_p1    <= w_spec_m;
      r_spec_zero_p1 <= w_spec_zero;
      r_spec_inv_p1  <= w_spec_inv;
    end
  end

  // ---- ALIGN: smaller mantissa plus guard bit shifted right by the exponent difference
  logic [MAN_W:0] w_s_al;
  logic [MAN_W:0] r_s_al_p2;

  assign w_s_al = (r_d_p1 > MAN_W_X) ? '0 : ({r_s_m_p1, 1'b0} >> r_d_p1);

  always_ff @(posedge clk) begin
    if (r_state == S_ALIGN) r_s_al_p2 <= w_s_al;
  end

  // ---- ADDSUB: carry + mantissa + guard; never negative because L >= S
  logic [SW-1:0] w_l_x, w_s_x, w_sum;
  logic [SW-1:0] r_sum_p3;

  assign w_l_x = {1'b0, r_l_m_p1, 1'b0};
  assign w_s_x = {1'b0, r_s_al_p2};
  assign w_sum = r_eff_sub_p1 ? (w_l_x - w_s_x) : (w_l_x + w_s_x);

  always_ff @(posedge clk) begin
    if (r_state == S_ADDSUB) r_sum_p3 <= w_sum;
  end

  // ---- NORM: carry shifts right, otherwise shift left by the leading-zero count
  logic [XW-1:0]        w_lz;
  logic [MAN_W:0]       w_norm_m;
  logic signed [XW-1:0] w_norm_e;
  logic                 w_cancel;
  logic [MAN_W:0]       r_nm_p4;
  logic signed [XW-1:0] r_ne_p4;
  logic                 r_cancel_p4;

  assign w_lz     = lead_zeros(r_sum_p3[MAN_W:0]);
  assign w_cancel = (r_sum_p3 == '0);

  always_comb begin
    if (r_sum_p3[SW-1]) begin
      w_norm_m = r_sum_p3[SW-1:1];
      w_norm_e = r_l_e_p1 + ONE_X;
    end else begin
      w_norm_m = r_sum_p3[MAN_W:0] << w_lz;
      w_norm_e = r_l_e_p1 - $signed(w_lz);
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_NORM) begin
      r_nm_p4     <= w_norm_m;
      r_ne_p4     <= w_norm_e;
      r_cancel_p4 <= w_cancel;
    end
  end

  // ---- ROUND: rounding, renormalisation, range check and result selection
  logic [MAN_W:0]       w_rnd;
  logic [MAN_W-1:0]     w_fin_m;
  logic signed [XW-1:0] w_fin_e;
  logic                 w_res_s, w_zero, w_ovf, w_unf, w_inv;
  logic [EXP_W-1:0]     w_res_e;
  logic [MAN_W-1:0]     w_res_m;

  assign w_rnd   = round_man(r_nm_p4);
  assign w_fin_m = w_rnd[MAN_W] ? CANON_M : w_rnd[MAN_W-1:0];
  assign w_fin_e = w_rnd[MAN_W] ? (r_ne_p4 + ONE_X) : r_ne_p4;

  always_comb begin
    w_res_s = 1'b0;
    w_res_e = EMIN;
    w_res_m = CANON_M;
    w_zero  = 1'b0;
    w_ovf   = 1'b0;
    w_unf   = 1'b0;
    w_inv   = 1'b0;
    if (r_spec_p1) begin
      w_res_s = r_spec_s_p1;
      w_res_e = r_spec_e_p1;
      w_res_m = r_spec_m_p1;
      w_zero  = r_spec_zero_p1;
      w_inv   = r_spec_inv_p1;
    end else if (r_cancel_p4) begin
      w_zero = 1'b1;
    end else if (w_fin_e > EHI_X) begin
      w_res_s = r_l_s_p1;
      w_res_e = EMAX;
      w_ovf   = 1'b1;
    end else if (w_fin_e < ELO_X) begin
      w_unf  = 1'b1;
      w_zero = 1'b1;
    end else begin
      w_res_s = r_l_s_p1;
      w_res_e = w_fin_e[EXP_W-1:0];
      w_res_m = w_fin_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_s          <= 1'b0;
      res_e          <= EMIN;
      res_m          <= CANON_M;
      zero_flag      <= 1'b0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      invalid_flag   <= 1'b0;
    end else if (r_state == S_ROUND) begin
      res_s          <= w_res_s;
      res_e          <= w_res_e;
      res_m          <= w_res_m;
      zero_flag      <= w_zero;
      overflow_flag  <= w_ovf;
      underflow_flag <= w_unf;
      invalid_flag   <= w_inv;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe at default widths (EXP_W=7, MAN_W=15).
module tb_fpu_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset, start, sub, a_s, b_s;
  logic [6:0]  a_e, b_e;
  logic [14:0] a_m, b_m;
  logic        res_s;
  logic [6:0]  res_e;
  logic [14:0] res_m;
  logic        zero_flag, overflow_flag, underflow_flag, invalid_flag, busy, done;

  int tests = 0;
  int fails = 0;

`ifdef FPU_ROUND_EN
  localparam logic [14:0] RND_M = 15'h4001;
`else
  localparam logic [14:0] RND_M = 15'h4000;
`endif

  always #5 clk = ~clk;

  fpu_addsub_pipe dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub),
    .a_s(a_s), .b_s(b_s), .a_e(a_e), .b_e(b_e), .a_m(a_m), .b_m(b_m),
    .res_s(res_s), .res_e(res_e), .res_m(res_m),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag),
    .underflow_flag(underflow_flag), .invalid_flag(invalid_flag),
    .busy(busy), .done(done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  // Issue one operation, scramble inputs after the start cycle, wait (bounded) for done.
  task automatic issue(input logic as, input logic [6:0] ae, input logic [14:0] am,
                       input logic bs, input logic [6:0] be, input logic [14:0] bm,
                       input logic sb, output int lat, output logic busy1);
    @(negedge clk);
    a_s = as; a_e = ae; a_m = am; b_s = bs; b_e = be; b_m = bm; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_s = ~as; b_s = ~bs; sub = ~sb; a_e = 7'h2A; b_e = 7'h15; a_m = 15'h1234; b_m = 15'h7777;
    busy1 = busy;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sub = 1'b0; a_s = 1'b0; b_s = 1'b0;
    a_e = '0; b_e = '0; a_m = '0; b_m = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h40, 15'h4000}) begin
      $display("FAIL reset_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h40, 15'h4000});
      fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000", {zero_flag, overflow_flag, underflow_flag, invalid_flag});
      fails++;
    end
    tests++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL reset_busy_done: got %b want 00", {busy, done});
      fails++;
    end
  endtask

  task automatic test_add_one();
    int lat; logic b1;
    issue(1'b0, 7'h00, 15'h4000, 1'b0, 7'h00, 15'h4000, 1'b0, lat, b1);
    tests++;
    if (lat !== 6) begin
      $display("FAIL add_latency: got %0d want 6", lat); fails++;
    end
    tests++;
    if (b1 !== 1'b1) begin
      $display("FAIL add_busy_cycle1: got %b want 1", b1); fails++;
    end
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h01, 15'h4000}) begin
      $display("FAIL add_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h01, 15'h4000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0000) begin
      $display("FAIL add_flags: got %b want 0000", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
    @(posedge clk); #1;
    tests++;
    if ({done, busy} !== 2'b00) begin
      $display("FAIL add_done_pulse: got %b want 00", {done, busy}); fails++;
    end
  endtask

  task automatic test_sub_sign();
    int lat; logic b1;
    // 1.0 - 3.0 = -2.0
    issue(1'b0, 7'h00, 15'h4000, 1'b0, 7'h01, 15'h6000, 1'b1, lat, b1);
    tests++;
    if ({res_s, res_e, res_m} !== {1'b1, 7'h01, 15'h4000}) begin
      $display("FAIL sub_sign_result: got %h want %h", {res_s, res_e, res_m}, {1'b1, 7'h01, 15'h4000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0000) begin
      $display("FAIL sub_sign_flags: got %b want 0000", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
  endtask

  task automatic test_zero_operand();
    int lat; logic b1;
    // 0 - (e=3, m=0x5000): B returned with its effective (negated) sign
    issue(1'b0, 7'h40, 15'h4000, 1'b0, 7'h03, 15'h5000, 1'b1, lat, b1);
    tests++;
    if ({res_s, res_e, res_m} !== {1'b1, 7'h03, 15'h5000}) begin
      $display("FAIL zero_operand_result: got %h want %h", {res_s, res_e, res_m}, {1'b1, 7'h03, 15'h5000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0000) begin
      $display("FAIL zero_operand_flags: got %b want 0000", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
  endtask

  task automatic test_cancel();
    int lat; logic b1;
    issue(1'b0, 7'h00, 15'h6000, 1'b0, 7'h00, 15'h6000, 1'b1, lat, b1);
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h40, 15'h4000}) begin
      $display("FAIL cancel_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h40, 15'h4000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b1000) begin
      $display("FAIL cancel_flags: got %b want 1000", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
  endtask

  task automatic test_overflow();
    int lat; logic b1;
    issue(1'b0, 7'h3E, 15'h4000, 1'b0, 7'h3E, 15'h4000, 1'b0, lat, b1);
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h3F, 15'h4000}) begin
      $display("FAIL overflow_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h3F, 15'h4000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0100) begin
      $display("FAIL overflow_flags: got %b want 0100", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
  endtask

  task automatic test_underflow();
    int lat; logic b1;
    issue(1'b0, 7'h41, 15'h6000, 1'b0, 7'h41, 15'h4000, 1'b1, lat, b1);
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h40, 15'h4000}) begin
      $display("FAIL underflow_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h40, 15'h4000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b1010) begin
      $display("FAIL underflow_flags: got %b want 1010", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
  endtask

  task automatic test_infinity();
    int lat; logic b1;
    issue(1'b0, 7'h3F, 15'h4000, 1'b0, 7'h3F, 15'h4000, 1'b1, lat, b1);
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h3F, 15'h4000}) begin
      $display("FAIL inf_minus_inf_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h3F, 15'h4000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0001) begin
      $display("FAIL inf_minus_inf_flags: got %b want 0001", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
    issue(1'b0, 7'h3F, 15'h4000, 1'b0, 7'h05, 15'h5000, 1'b0, lat, b1);
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h3F, 15'h4000}) begin
      $display("FAIL inf_plus_x_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h3F, 15'h4000}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0000) begin
      $display("FAIL inf_plus_x_flags: got %b want 0000", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
  endtask

  task automatic test_round_busy_reset();
    int lat; int n;
    // 1.0 + 2^-15, with a second start pulsed in cycle 2 that must be ignored
    @(negedge clk);
    a_s = 1'b0; a_e = 7'h00; a_m = 15'h4000; b_s = 1'b0; b_e = 7'h71; b_m = 15'h4000; sub = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    a_e = 7'h00; b_e = 7'h00; b_m = 15'h4000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== 6) begin
      $display("FAIL round_latency: got %0d want 6", lat); fails++;
    end
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h00, RND_M}) begin
      $display("FAIL round_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h00, RND_M}); fails++;
    end
    tests++;
    if ({zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 4'b0000) begin
      $display("FAIL round_flags: got %b want 0000", {zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) n++;
    end
    tests++;
    if (n !== 0) begin
      $display("FAIL ignored_start_done: got %0d extra done pulses want 0", n); fails++;
    end
    // Reset asserted in cycle 3 aborts the operation
    @(negedge clk);
    a_s = 1'b0; a_e = 7'h00; a_m = 15'h4000; b_s = 1'b0; b_e = 7'h00; b_m = 15'h4000; sub = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tests++;
    if ({res_s, res_e, res_m} !== {1'b0, 7'h40, 15'h4000}) begin
      $display("FAIL abort_result: got %h want %h", {res_s, res_e, res_m}, {1'b0, 7'h40, 15'h4000}); fails++;
    end
    tests++;
    if ({busy, zero_flag, overflow_flag, underflow_flag, invalid_flag} !== 5'b00000) begin
      $display("FAIL abort_busy_flags: got %b want 00000", {busy, zero_flag, overflow_flag, underflow_flag, invalid_flag}); fails++;
    end
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) n++;
    end
    tests++;
    if (n !== 0) begin
      $display("FAIL abort_done: got %0d done pulses want 0", n); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_add_one();
    test_sub_sign();
    test_zero_operand();
    test_cancel();
    test_overflow();
    test_underflow();
    test_infinity();
    test_round_busy_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_pipe.md
# fpu_addsub_pipe

Parametrised multi-cycle floating-point adder/subtractor for the tinyZuse datapath. It supersedes the fixed 7/15-bit add/sub unit and adds the following:
- generic exponent and mantissa widths;
- operand capture on a start/done handshake;
- correct handling of zero operands;
- an invalid flag for ∞−∞;
- a fixed latency;
- optional round-to-nearest.

It sits between the register file and the result register and is driven by the sequencer.

## Interface
- EXP_W, 7: exponent width, two's complement.
- MAN_W, 15: mantissa width, explicit leading one at bit MAN_W-1.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- sub  in  1  0: A+B, 1: A−B; captured with start.
- a_s, b_s  in  1  operand signs.
- a_e, b_e  in  EXP_W  operand exponents.
- a_m, b_m  in  MAN_W  operand mantissas.
- res_s  out  1  result sign.
- res_e  out  EXP_W  result exponent.
- res_m  out  MAN_W  result mantissa.
- zero_flag, overflow_flag, underflow_flag, invalid_flag  out  1  status of the last result.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when the result is valid.

## Operation
Number format:
- Value = (−1)^s · m/2^(MAN_W−1) · 2^e.
- Let EMAX = 2^(EXP_W−1)−1 and EMIN = −2^(EXP_W−1).
- e=EMAX encodes ∞. e=EMIN encodes zero; the canonical zero mantissa is 1 followed by zeros.
- Finite exponents lie in EMIN+1..EMAX−1.

State machine (IDLE → UNPACK → ALIGN → ADDSUB → NORM → ROUND → DONE → IDLE):
- IDLE: when start=1, latch all operands and sub, then go to UNPACK. Input ports are don't-care after the start cycle.
- UNPACK:
  - Effective B sign = b_s^sub; effective subtract = a_s≠(b_s^sub).
  - Swap so the larger magnitude is L: compare exponents, then mantissas on a tie.
  - Compute d = L.e−S.e (EXP_W+1 bits, non-negative).
  - Detect specials.
- ALIGN: S.m is extended by one guard bit (MAN_W+1 bits) and shifted right by d. If d > MAN_W, the aligned value is 0.
- ADDSUB: L±S in MAN_W+2 bits (carry plus guard). The result is never negative, because of the swap.
- NORM:
  - On carry: shift right 1 and set exponent = L.e+1.
  - Otherwise: leading-zero count lz via a priority encoder, shift left by lz, exponent = L.e−lz.
  - An all-zero sum is an exact cancellation.
- ROUND: apply rounding (see Configuration). A mantissa carry-out from rounding renormalises to 1 followed by zeros and increments the exponent. Then apply the range check.
- DONE: outputs registered, done=1, busy=0 on the following cycle.

Result rules, highest priority first:
1. ∞ with effective subtract against ∞: res = +∞ (s=0, e=EMAX, m=1 followed by zeros), invalid_flag=1.
2. Either operand ∞: ∞ with that operand's effective sign.
3. Both zero: canonical zero, s=0, zero_flag=1.
4. One zero: the other operand unchanged, with its effective sign.
5. Exact cancellation: canonical zero, s=0, zero_flag=1.
6. Exponent > EMAX−1: ∞ with sign L.s, overflow_flag=1.
7. Exponent < EMIN+1: canonical zero with sign 0; underflow_flag=1 and zero_flag=1.
8. Otherwise: sign L.s with the normalised exponent and mantissa.

Arithmetic width rule: exponent arithmetic is EXP_W+1 bits signed, so the range check never wraps.

## Timing
- Reset values: res_s=0, res_e=EMIN, res_m=1 followed by zeros, all flags 0, busy=0, done=0, state=IDLE.
- Latency: start is sampled in cycle 0; busy=1 in cycles 1–5; done=1 in cycle 6 only. busy=0 from cycle 6, so back-to-back issue gives a throughput of one operation per 6 cycles.
- A start asserted while busy=1 is ignored. It is not queued.
- res_* and flags update only in the cycle done rises, and hold until the next done.
- Flags are recomputed for each operation; they never accumulate across operations.
- Reset mid-operation aborts: no done pulse is produced and outputs return to their reset values.

## Configuration
- FPU_ROUND_EN defined: round to nearest, ties away from zero. The guard bit is added at the LSB; the renormalisation step above applies.
- FPU_ROUND_EN undefined: truncate. The guard bit is discarded and the rounding adder is not built.
- Latency is 6 cycles in both builds; ROUND becomes a register-only stage when rounding is disabled.

## Test plan
All scenarios use the default widths; A is listed first.
- 1.0+1.0 (s0,e0,m0x4000 for both), sub=0 → res e=0x01, m=0x4000, s=0; done exactly 6 cycles after start; no flags.
- 1.5−1.5 (m0x6000, e0 for both), sub=1 → e=0x40, m=0x4000, s=0, zero_flag=1.
- (e=62, m0x4000)+(e=62, m0x4000) → e=0x3F, m=0x4000, overflow_flag=1.
- (e=0x41, m0x6000)−(e=0x41, m0x4000) → e=0x40, m=0x4000, s=0; underflow_flag=1 and zero_flag=1.
- +∞−(+∞) (e=0x3F for both), sub=1 → +∞, invalid_flag=1. Separately, ∞+(e=5, m0x5000) → ∞, no invalid flag.
- 1.0 (e0, m0x4000) + 2^−15 (e=0x71, m0x4000):
  - with FPU_ROUND_EN: m=0x4001, e=0;
  - without: m=0x4000, e=0.
  - Also in this scenario: pulse start again during busy and confirm it is ignored; assert reset in cycle 3 and confirm no done pulse and reset output values.
